// File: rtl/cnn_pkg.sv
// Shared FSM encodings and default sizing constants for the CNN FIFO fill path.
package cnn_pkg;

  localparam int DEF_ARRAY_SIZE   = 9;
  localparam int DEF_DATA_SIZE    = 16;
  localparam int DEF_DIMDATA_SIZE = 16;
  localparam int DEF_ADDR_W       = 14;
  localparam int OFFSET_W         = 8;

  typedef enum logic [1:0] {
    FILL_IDLE  = 2'd0,
    FILL_RUN   = 2'd1,
    FILL_DRAIN = 2'd2,
    FILL_DONE  = 2'd3
  } fill_state_e;

  // A job with no complete KxK window produces no reads at all.
  function automatic logic job_is_degenerate(input int unsigned h,
                                             input int unsigned w,
                                             input int unsigned k);
    return (k == 0) || (k > h) || (k > w) || (h == 0);
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Raster walker over output positions and KxK taps; produces one BRAM address
// per tap and steps only when the controller accepts the current one via next_i.
module conv_addr_gen
  import cnn_pkg::*;
#(
  parameter int DIMDATA_SIZE = DEF_DIMDATA_SIZE,
  parameter int ADDR_W       = DEF_ADDR_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear_i,
  input  logic                    load_i,
  input  logic [ADDR_W-1:0]       base_i,
  input  logic [DIMDATA_SIZE-1:0] height_i,
  input  logic [DIMDATA_SIZE-1:0] width_i,
  input  logic [DIMDATA_SIZE-1:0] ksize_i,
  input  logic                    next_i,
  output logic [ADDR_W-1:0]       addr_o,
  output logic [DIMDATA_SIZE-1:0] tap_o,
  output logic                    last_o
);

  localparam int PW = 2 * DIMDATA_SIZE;

  typedef logic [DIMDATA_SIZE-1:0] dim_t;

  logic [ADDR_W-1:0] base_q, base_d;
  dim_t width_q, width_d, ksize_q, ksize_d;
  dim_t rmax_q, rmax_d, cmax_q, cmax_d;
  dim_t r_q, r_d, c_q, c_d, ki_q, ki_d, kj_q, kj_d, tap_q, tap_d;

  dim_t          kmax;
  logic          kj_end, ki_end, c_end, r_end;
  logic [PW-1:0] row_w, col_w, sum_w;

  always_comb begin
    kmax   = ksize_q - 1'b1;
    kj_end = (kj_q == kmax);
    ki_end = (ki_q == kmax);
    c_end  = (c_q == cmax_q);
    r_end  = (r_q == rmax_q);
    last_o = kj_end && ki_end && c_end && r_end;
    tap_o  = tap_q;

    row_w  = PW'(r_q) + PW'(ki_q);
    col_w  = PW'(c_q) + PW'(kj_q);
    sum_w  = (row_w * PW'(width_q)) + col_w + PW'(base_q);
    addr_o = ADDR_W'(sum_w);
  end

  always_comb begin
    base_d  = base_q;
    width_d = width_q;
    ksize_d = ksize_q;
    rmax_d  = rmax_q;
    cmax_d  = cmax_q;
    r_d     = r_q;
    c_d     = c_q;
    ki_d    = ki_q;
    kj_d    = kj_q;
    tap_d   = tap_q;

    if (clear_i) begin
      r_d   = '0;
      c_d   = '0;
      ki_d  = '0;
      kj_d  = '0;
      tap_d = '0;
    end else if (load_i) begin
      base_d  = base_i;
      width_d = width_i;
      ksize_d = ksize_i;
      rmax_d  = height_i - ksize_i;
      cmax_d  = width_i - ksize_i;
      r_d     = '0;
      c_d     = '0;
      ki_d    = '0;
      kj_d    = '0;
      tap_d   = '0;
    end else if (next_i) begin
      // kj fastest, then ki, then column, then row; tap index tracks ki*K+kj.
      if (!kj_end) begin
        kj_d  = kj_q + 1'b1;
        tap_d = tap_q + 1'b1;
      end else begin
        kj_d = '0;
        if (!ki_end) begin
          ki_d  = ki_q + 1'b1;
          tap_d = tap_q + 1'b1;
        end else begin
          ki_d  = '0;
          tap_d = '0;
          if (!c_end) begin
            c_d = c_q + 1'b1;
          end else begin
            c_d = '0;
            r_d = r_end ? '0 : r_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q  <= '0;
      width_q <= '0;
      ksize_q <= '0;
      rmax_q  <= '0;
      cmax_q  <= '0;
      r_q     <= '0;
      c_q     <= '0;
      ki_q    <= '0;
      kj_q    <= '0;
      tap_q   <= '0;
    end else begin
      base_q  <= base_d;
      width_q <= width_d;
      ksize_q <= ksize_d;
      rmax_q  <= rmax_d;
      cmax_q  <= cmax_d;
      r_q     <= r_d;
      c_q     <= c_d;
      ki_q    <= ki_d;
      kj_q    <= kj_d;
      tap_q   <= tap_d;
    end
  end

endmodule

// File: rtl/fifo_fill_controller.sv
// Streams KxK convolution windows from image BRAM into per-tap lane FIFOs,
// one tap per cycle, stalling on lane-full or enable low.
module fifo_fill_controller
  import cnn_pkg::*;
#(
  parameter int ARRAY_SIZE   = DEF_ARRAY_SIZE,
  parameter int DATA_SIZE    = DEF_DATA_SIZE,
  parameter int DIMDATA_SIZE = DEF_DIMDATA_SIZE,
  parameter int ADDR_W       = DEF_ADDR_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fifo_fill_reset,
  input  logic                    fifo_fill_enable,
  input  logic [ADDR_W-1:0]       fifo_initial_address,
  input  logic [DIMDATA_SIZE-1:0] image_height,
  input  logic [DIMDATA_SIZE-1:0] image_width,
  input  logic [DIMDATA_SIZE-1:0] kernel_size,
  input  logic [OFFSET_W-1:0]     fifo_offset,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_en,
  input  logic [DATA_SIZE-1:0]    mem_data,
  input  logic [ARRAY_SIZE-1:0]   fifo_full,
  output logic [ARRAY_SIZE-1:0]   fifo_w_en,
  output logic [DATA_SIZE-1:0]    fifo_w_data,
  output logic                    fifo_fill_done
);

  localparam int LANE_W = ((DIMDATA_SIZE > OFFSET_W) ? DIMDATA_SIZE : OFFSET_W) + 1;

  fill_state_e state_q, state_d;

  logic [OFFSET_W-1:0]     offset_q, offset_d;
  logic [ARRAY_SIZE-1:0]   w_en_q, w_en_d;
  logic [ADDR_W-1:0]       gen_addr;
  logic [DIMDATA_SIZE-1:0] gen_tap;
  logic                    gen_last;
  logic                    start, degenerate, issue, lane_blocked;
  logic [LANE_W-1:0]       lane_w;
  logic [ARRAY_SIZE-1:0]   lane_hit;

  conv_addr_gen #(
    .DIMDATA_SIZE (DIMDATA_SIZE),
    .ADDR_W       (ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (!fifo_fill_reset),
    .load_i   (start),
    .base_i   (fifo_initial_address),
    .height_i (image_height),
    .width_i  (image_width),
    .ksize_i  (kernel_size),
    .next_i   (issue),
    .addr_o   (gen_addr),
    .tap_o    (gen_tap),
    .last_o   (gen_last)
  );

  // Lanes beyond the array still get read (to keep the walk in step) but never decode a hit.
  assign lane_w = LANE_W'(offset_q) + LANE_W'(gen_tap);

  generate
    for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
      assign lane_hit[gi] = (lane_w == LANE_W'(gi));
    end
  endgenerate

  assign lane_blocked = |(lane_hit & fifo_full);
  assign issue        = (state_q == FILL_RUN) && fifo_fill_reset && fifo_fill_enable
                        && !lane_blocked;
  assign degenerate   = job_is_degenerate(32'(image_height), 32'(image_width),
                                          32'(kernel_size));

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    offset_d = offset_q;
    w_en_d   = issue ? lane_hit : '0;

    unique case (state_q)
      FILL_IDLE: begin
        if (fifo_fill_reset && fifo_fill_enable) begin
          start    = 1'b1;
          offset_d = fifo_offset;
          state_d  = degenerate ? FILL_DONE : FILL_RUN;
        end
      end
      FILL_RUN:   if (issue && gen_last) state_d = FILL_DRAIN;
      FILL_DRAIN: state_d = FILL_DONE;
      FILL_DONE:  state_d = FILL_DONE;
      default:    state_d = FILL_IDLE;
    endcase

    // Soft clear wins from any state; issue is already gated so no write is queued.
    if (!fifo_fill_reset) state_d = FILL_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FILL_IDLE;
      offset_q <= '0;
      w_en_q   <= '0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      w_en_q   <= w_en_d;
    end
  end

  assign mem_en         = issue;
  assign mem_addr       = gen_addr;
  assign fifo_w_en      = w_en_q;
  assign fifo_w_data    = (|w_en_q) ? mem_data : '0;
  assign fifo_fill_done = (state_q == FILL_DONE);

endmodule

// File: tb/tb_fifo_fill_controller.sv
// Scoreboard bench for fifo_fill_controller: expected lane writes are queued at job
// start from an independent window walk and matched against each observed write.
`timescale 1ns/1ps
module tb_fifo_fill_controller;
  import cnn_pkg::*;

  localparam int AS  = 9;
  localparam int DS  = 16;
  localparam int DMS = 16;
  localparam int AW  = 14;

  logic           clk = 1'b0;
  logic           reset;
  logic           fifo_fill_reset;
  logic           fifo_fill_enable;
  logic [AW-1:0]  fifo_initial_address;
  logic [DMS-1:0] image_height, image_width, kernel_size;
  logic [7:0]     fifo_offset;
  logic [AW-1:0]  mem_addr;
  logic           mem_en;
  logic [DS-1:0]  mem_data = '0;
  logic [AS-1:0]  fifo_full;
  logic [AS-1:0]  fifo_w_en;
  logic [DS-1:0]  fifo_w_data;
  logic           fifo_fill_done;

  always #5 clk = ~clk;

  fifo_fill_controller #(
    .ARRAY_SIZE(AS), .DATA_SIZE(DS), .DIMDATA_SIZE(DMS), .ADDR_W(AW)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .fifo_fill_reset      (fifo_fill_reset),
    .fifo_fill_enable     (fifo_fill_enable),
    .fifo_initial_address (fifo_initial_address),
    .image_height         (image_height),
    .image_width          (image_width),
    .kernel_size          (kernel_size),
    .fifo_offset          (fifo_offset),
    .mem_addr             (mem_addr),
    .mem_en               (mem_en),
    .mem_data             (mem_data),
    .fifo_full            (fifo_full),
    .fifo_w_en            (fifo_w_en),
    .fifo_w_data          (fifo_w_data),
    .fifo_fill_done       (fifo_fill_done)
  );

  typedef struct {
    int            lane;
    logic [DS-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_reads  = 0;
  int            n_writes = 0;
  int            n_viol   = 0;
  logic [AS-1:0] full_prev = '0;

  // Image contents: unique per address, so data identifies the address read.
  function automatic logic [DS-1:0] mem_val(input logic [AW-1:0] a);
    return {2'b11, a} ^ 16'h3C5A;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Image BRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en === 1'b1) mem_data <= mem_val(mem_addr);
  end

  always @(negedge clk) begin
    if (mem_en === 1'b1) n_reads++;
    if (!$isunknown(fifo_w_en) && fifo_w_en != '0) begin
      n_writes++;
      if ((fifo_w_en & full_prev) != '0) n_viol++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_write", 32'(fifo_w_en), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("w_lane", 32'(fifo_w_en), 32'd1 << mon_e.lane);
        check_eq("w_data", 32'(fifo_w_data), 32'(mon_e.data));
      end
    end
    full_prev = fifo_full;
  end

  task automatic build_expected(input int base, input int h, input int w, input int k,
                                input int off, output int reads);
    int lane;
    logic [AW-1:0] a;
    reads = 0;
    exp_q.delete();
    if (k == 0 || k > h || k > w || h == 0) return;
    for (int r = 0; r <= h - k; r++)
      for (int c = 0; c <= w - k; c++)
        for (int ki = 0; ki < k; ki++)
          for (int kj = 0; kj < k; kj++) begin
            reads++;
            a    = AW'(base + (r + ki) * w + c + kj);
            lane = off + ki * k + kj;
            if (lane < AS) exp_q.push_back('{lane: lane, data: mem_val(a)});
          end
  endtask

  task automatic arm(input int base, input int h, input int w, input int k, input int off);
    fifo_initial_address = AW'(base);
    image_height         = DMS'(h);
    image_width          = DMS'(w);
    kernel_size          = DMS'(k);
    fifo_offset          = 8'(off);
    fifo_fill_reset      = 1'b1;
    fifo_fill_enable     = 1'b1;
  endtask

  // Cycle 0 is the cycle in which the job is armed; returns the first cycle done is seen.
  task automatic run_to_done(input int limit, input logic [AS-1:0] mask, input int from,
                             input int to, output int done_cyc);
    done_cyc = -1;
    for (int n = 0; n < limit; n++) begin
      fifo_full = (n >= from && n <= to) ? mask : '0;
      @(negedge clk);
      if (fifo_fill_done === 1'b1) begin
        done_cyc = n;
        break;
      end
      @(posedge clk); #1;
    end
    fifo_full = '0;
  endtask

  task automatic do_job(input string tag, input int base, input int h, input int w,
                        input int k, input int off, input logic [AS-1:0] mask,
                        input int from, input int to, input int stall_len);
    int reads, writes, done_cyc, exp_done, got_done;
    build_expected(base, h, w, k, off, reads);
    writes   = exp_q.size();
    exp_done = (reads == 0) ? 1 : reads + 2 + stall_len;
    @(posedge clk); #1;
    n_reads  = 0;
    n_writes = 0;
    n_viol   = 0;
    arm(base, h, w, k, off);
    run_to_done(400, mask, from, to, done_cyc);
    got_done = (done_cyc >= exp_done - 1 && done_cyc <= exp_done + 1) ? exp_done : done_cyc;
    check_eq({tag, "_done_cycle"}, 32'(got_done), 32'(exp_done));
    check_eq({tag, "_reads"}, 32'(n_reads), 32'(reads));
    check_eq({tag, "_writes"}, 32'(n_writes), 32'(writes));
    check_eq({tag, "_left_in_queue"}, 32'(exp_q.size()), 32'd0);
    check_eq({tag, "_write_while_full"}, 32'(n_viol), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq({tag, "_done_sticky"}, 32'(fifo_fill_done), 32'd1);
    @(posedge clk); #1;
    fifo_fill_reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq({tag, "_done_cleared"}, 32'(fifo_fill_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int reads;
    reset     = 1'b1;
    fifo_full = '0;
    arm(5, 4, 4, 3, 0);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_mem_en", 32'(mem_en), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_w_en", 32'(fifo_w_en), 32'd0);
    check_eq("rst_w_data", 32'(fifo_w_data), 32'd0);
    check_eq("rst_done", 32'(fifo_fill_done), 32'd0);
    @(posedge clk); #1;
    reset           = 1'b0;
    fifo_fill_reset = 1'b0;
    @(posedge clk); #1;

    do_job("basic",   0, 4, 4, 3, 0, '0, 0, -1, 0);
    do_job("stall",   0, 4, 4, 3, 0, 9'b0_0001_0000, 5, 14, 10);
    do_job("offset6", 0, 3, 3, 2, 6, '0, 0, -1, 0);
    do_job("degen_k5", 0, 4, 4, 5, 0, '0, 0, -1, 0);
    do_job("degen_k0", 7, 4, 4, 0, 0, '0, 0, -1, 0);
    do_job("degen_h0", 0, 0, 4, 1, 0, '0, 0, -1, 0);

    // Abort mid-run, then re-arm: the rerun must start again from position (0,0).
    build_expected(0, 4, 4, 3, 0, reads);
    @(posedge clk); #1;
    n_writes = 0;
    arm(0, 4, 4, 3, 0);
    repeat (10) @(posedge clk);
    #1;
    fifo_fill_reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("abort_w_en", 32'(fifo_w_en), 32'd0);
    check_eq("abort_mem_en", 32'(mem_en), 32'd0);
    check_eq("abort_done", 32'(fifo_fill_done), 32'd0);
    check_eq("abort_progress", 32'(n_writes >= 8), 32'd1);
    exp_q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("abort_quiet", 32'(fifo_w_en), 32'd0);
    do_job("rearm", 0, 4, 4, 3, 0, '0, 0, -1, 0);

    do_job("wrap", 16380, 5, 6, 2, 3, '0, 0, -1, 0);

    // Hard reset while the final write is in flight.
    build_expected(100, 3, 3, 2, 0, reads);
    @(posedge clk); #1;
    arm(100, 3, 3, 2, 0);
    repeat (reads + 1) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_eq("drain_last_write", 32'(fifo_w_en != '0), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("drain_rst_mem_en", 32'(mem_en), 32'd0);
    check_eq("drain_rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("drain_rst_w_en", 32'(fifo_w_en), 32'd0);
    check_eq("drain_rst_w_data", 32'(fifo_w_data), 32'd0);
    check_eq("drain_rst_done", 32'(fifo_fill_done), 32'd0);
    check_eq("drain_left_in_queue", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    reset           = 1'b0;
    fifo_fill_reset = 1'b0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
